test_pattern_sequencer: RTL and testbench
=========================================

// Module: test_pattern_sequencer
// PURPOSE
//  Drives the ain/bin stimulus pins of the on-board test-output pattern generator.
//  Replaces free-running switches with a controlled burst: programmable rate, pattern mode and edge count.
//  Gives the analyzer a repeatable, countable capture target.
//  Sits between the host control registers (start/stop/config) and the pattern generator inputs.
// PARAMETERS
//  DIV_W  16  width of rate divider; tick period = div+1 clk cycles
//  CNT_W  16  width of burst length and ain rising-edge counter
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      1-cycle request to begin a burst (sampled in IDLE only)
//  stop       in   1      abort request; level, sampled every cycle
//  div        in   DIV_W  rate divider, latched on start accept
//  burst_len  in   CNT_W  ain rising edges per burst, latched on start; 0 = run until stop
//  mode       in   2      00 binary, 01 gray, 10 pulse, 11 complementary; latched on start
//  ain        out  1      stimulus A to pattern generator, registered
//  bin        out  1      stimulus B to pattern generator, registered
//  busy       out  1      high while in RUN
//  done       out  1      1-cycle pulse on normal burst completion
//  aborted    out  1      1-cycle pulse when stop ends a RUN
//  edge_cnt   out  CNT_W  ain rising edges in current/last burst
// BEHAVIOUR
//  Reset
//   - state=IDLE; ain, bin, busy, done, aborted = 0; edge_cnt = 0.
//   - Internal prescaler (pre) and 2-bit phase = 0.
//   - Reset mid-RUN takes effect on the same edge; no done or aborted pulse.
//  State machine
//   - IDLE -> RUN when start=1 and stop=0; stop wins on simultaneous start+stop.
//   - RUN  -> IDLE on stop=1, or on burst completion.
//   - start while in RUN is ignored.
//  Start accept (edge 0)
//   - Latch div/burst_len/mode; clear edge_cnt, pre and phase.
//   - At edge 1: busy=1 and outputs show phase 0.
//  Prescaler
//   - In RUN, pre counts 0..div; tick = (pre==div); pre wraps to 0 on tick.
//   - div=0 ticks every cycle.
//   - phase += 1 (mod 4) on tick, so phase changes at edges 1+k*(div+1).
//  Output map, registered, from next phase
//   - binary: {ain,bin} = phase.
//   - gray: {ain,bin} = phase ^ (phase>>1).
//   - pulse: ain = phase[0], bin = 0.
//   - complementary: ain = phase[0], bin = ~phase[0].
//  Edge counting
//   - edge_cnt += 1 on the edge where ain goes 0->1.
//   - edge_cnt saturates at all-ones (no wrap).
//  Completion (burst_len != 0)
//   - Once edge_cnt == burst_len, the next tick ends the burst.
//   - On that edge: state=IDLE, ain=bin=0, busy=0, done=1 for one cycle.
//   - edge_cnt holds its final value.
//  Abort
//   - stop=1 in RUN: next edge IDLE, ain=bin=0, busy=0, aborted=1 for one cycle.
//   - done is not asserted; edge_cnt holds.
//   - If completion and stop coincide on the same edge, done wins and aborted stays 0.
//  Other rules
//   - Outputs are 0 in IDLE in every mode.
//   - Config inputs are don't-care outside the start-accept cycle.
// TESTING
//  1. mode=00, div=1, burst_len=2, start at edge 0 -> ain rises at edges 5 and 13; done=1 at edge 15 only; edge_cnt=2; busy high edges 1..14.
//  2. mode=11, div=0, burst_len=0 -> bin=1 from edge 1; ain/bin toggle every cycle; stop at edge 20 -> edge 21 ain=bin=0, aborted=1, done=0, edge_cnt=10.
//  3. mode=01, div=3 -> {ain,bin} steps 00,01,11,10 every 4 cycles; ain rises once per 16 cycles.
//  4. start+stop same cycle in IDLE -> stays IDLE, busy=0; second start during RUN -> ignored, latched div unchanged.
//  5. rst asserted mid-RUN -> next edge all outputs 0, no done/aborted pulse; fresh start then behaves as scenario 1.
//  6. mode=10, div=0, burst_len=1 -> ain rises edge 2; done at edge 3; stop asserted at edge 2 -> done=1, aborted=0.

Source files
------------

// File: rtl/test_pattern_sequencer.sv
// Burst sequencer driving the ain/bin pins of the test-output pattern
// generator with programmable rate, pattern mode and rising-edge count.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, stop     : burst request (IDLE only) / abort level
//   div             : rate divider, tick period = div+1 cycles
//   burst_len       : ain rising edges per burst, 0 = until stop
//   mode            : 00 binary, 01 gray, 10 pulse, 11 complementary
//   ain, bin        : registered stimulus outputs
//   busy            : high while running
//   done, aborted   : one-cycle completion / abort pulses
//   edge_cnt        : ain rising edges in current/last burst
module test_pattern_sequencer #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [1:0]       mode,
  output logic             ain,
  output logic             bin,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0]       phase_q, phase_d;
  logic             ain_q, ain_d;
  logic             bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic tick;
  logic finish;

  // The first RUN cycle (busy_q still low) only loads phase 0 onto the
  // outputs; the prescaler starts counting from the cycle after, so the
  // visible phase steps at edges 1+k*(div+1) after the accept edge.
  assign accept = (state_q == S_IDLE) && start && !stop;
  assign tick   = busy_q && (pre_q == div_q);
  assign finish = (len_q != '0) && (cnt_q == len_q) && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      pre_q     <= '0;
      phase_q   <= '0;
      ain_q     <= 1'b0;
      bin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      ain_q     <= ain_d;
      bin_q     <= bin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (finish || stop) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    len_d     = len_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    phase_d   = phase_q;
    ain_d     = ain_q;
    bin_d     = bin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cnt_d     = cnt_q;

    if (accept) begin
      div_d   = div;
      len_d   = burst_len;
      mode_d  = mode;
      pre_d   = '0;
      phase_d = '0;
      cnt_d   = '0;
      ain_d   = 1'b0;
      bin_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      if (finish) begin
        // completion outranks a coincident stop
        ain_d  = 1'b0;
        bin_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (stop) begin
        ain_d     = 1'b0;
        bin_d     = 1'b0;
        busy_d    = 1'b0;
        aborted_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        if (busy_q) begin
          pre_d   = tick ? '0 : pre_q + DIV_W'(1);
          phase_d = phase_q + {1'b0, tick};
        end
        case (mode_q)
          2'b00: {ain_d, bin_d} = phase_d;
          2'b01: {ain_d, bin_d} = phase_d ^ {1'b0, phase_d[1]};
          2'b10: begin
            ain_d = phase_d[0];
            bin_d = 1'b0;
          end
          default: begin
            ain_d = phase_d[0];
            bin_d = ~phase_d[0];
          end
        endcase
        if (ain_d && !ain_q && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign ain      = ain_q;
  assign bin      = bin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Scoreboard bench for test_pattern_sequencer: stimulus pushes expected
// per-edge output records, a negedge monitor pops and compares them.
module tb_test_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] div;
  logic [15:0] burst_len;
  logic [1:0]  mode;
  logic        ain;
  logic        bin;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] edge_cnt;

  test_pattern_sequencer #(
    .DIV_W(16),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div      (div),
    .burst_len(burst_len),
    .mode     (mode),
    .ain      (ain),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .edge_cnt (edge_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  ab;
    logic        bz;
    logic        dn;
    logic        abt;
    logic [15:0] cn;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // binary, div=1, burst_len=2: {ain,bin} and edge_cnt for t=0..16
  localparam logic [1:0] S1_AB [0:16] =
    '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 0, 0};
  localparam logic [1:0] S1_CN [0:16] =
    '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};
  // gray code per phase
  localparam logic [1:0] GRAY [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic push(input int c, input logic [1:0] ab,
                      input logic bz, input logic dn,
                      input logic abt, input logic [15:0] cn);
    exp_t e;
    e.cyc = c;
    e.ab  = ab;
    e.bz  = bz;
    e.dn  = dn;
    e.abt = abt;
    e.cn  = cn;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL late_check due=%0d now=%0d", e.cyc, cyc);
      end else if ({ain, bin, busy, done, aborted, edge_cnt} !==
                   {e.ab, e.bz, e.dn, e.abt, e.cn}) begin
        errors++;
        $display({"FAIL outputs cyc=%0d got ab=%b busy=%b done=%b",
                  " abt=%b cnt=%0d want ab=%b busy=%b done=%b",
                  " abt=%b cnt=%0d"},
                 cyc, {ain, bin}, busy, done, aborted, edge_cnt,
                 e.ab, e.bz, e.dn, e.abt, e.cn);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [15:0] d, input logic [15:0] l,
                    input logic [1:0] m);
    div       = d;
    burst_len = l;
    mode      = m;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    div       = 16'h00ff;
    burst_len = 16'd7;
    mode      = ~m;
  endtask

  task automatic exp_s1(input int e0, input int last);
    for (int t = 0; t <= last; t++) begin
      logic bz;
      logic dn;
      bz = (t >= 1 && t <= 14);
      dn = (t == 15);
      push(e0 + t, S1_AB[t], bz, dn, 1'b0, 16'(S1_CN[t]));
    end
  endtask

  initial begin
    int e0;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    div       = '0;
    burst_len = '0;
    mode      = 2'b11;
    push(2, 2'b00, 0, 0, 0, 16'd0);
    push(3, 2'b00, 0, 0, 0, 16'd0);
    push(4, 2'b00, 0, 0, 0, 16'd0);
    wait_until(3);
    rst = 1'b0;
    wait_until(4);

    // binary burst of two ain edges
    e0 = cyc + 1;
    exp_s1(e0, 16);
    go(16'd1, 16'd2, 2'b00);
    wait_until(e0 + 16);

    // complementary, free-running, aborted by stop
    e0 = cyc + 1;
    push(e0, 2'b00, 0, 0, 0, 16'd0);
    for (int t = 1; t <= 20; t++) begin
      if (t % 2 == 1)
        push(e0 + t, 2'b01, 1, 0, 0, 16'((t - 1) / 2));
      else
        push(e0 + t, 2'b10, 1, 0, 0, 16'(t / 2));
    end
    push(e0 + 21, 2'b00, 0, 0, 1, 16'd10);
    push(e0 + 22, 2'b00, 0, 0, 0, 16'd10);
    go(16'd0, 16'd0, 2'b11);
    wait_until(e0 + 20);
    stop = 1'b1;
    wait_until(e0 + 21);
    stop = 1'b0;
    wait_until(e0 + 22);

    // gray, div=3, with an ignored restart mid-run
    e0 = cyc + 1;
    push(e0, 2'b00, 0, 0, 0, 16'd0);
    for (int t = 1; t <= 28; t++) begin
      logic [15:0] cn;
      cn = (t < 9) ? 16'd0 : (t < 25) ? 16'd1 : 16'd2;
      push(e0 + t, GRAY[((t - 1) / 4) % 4], 1, 0, 0, cn);
    end
    push(e0 + 29, 2'b00, 0, 0, 1, 16'd2);
    push(e0 + 30, 2'b00, 0, 0, 0, 16'd2);
    go(16'd3, 16'd0, 2'b01);
    wait_until(e0 + 9);
    div   = 16'd0;
    mode  = 2'b00;
    start = 1'b1;
    wait_until(e0 + 10);
    start = 1'b0;
    wait_until(e0 + 28);
    stop = 1'b1;
    wait_until(e0 + 29);
    stop = 1'b0;
    wait_until(e0 + 30);

    // start and stop together in IDLE: no burst, count untouched
    n = cyc;
    push(n + 1, 2'b00, 0, 0, 0, 16'd2);
    push(n + 2, 2'b00, 0, 0, 0, 16'd2);
    push(n + 3, 2'b00, 0, 0, 0, 16'd2);
    div       = 16'd0;
    burst_len = 16'd0;
    mode      = 2'b11;
    start     = 1'b1;
    stop      = 1'b1;
    wait_until(n + 1);
    start = 1'b0;
    stop  = 1'b0;
    wait_until(n + 3);

    // reset mid-run, then a fresh binary burst
    e0 = cyc + 1;
    exp_s1(e0, 6);
    push(e0 + 7, 2'b00, 0, 0, 0, 16'd0);
    push(e0 + 8, 2'b00, 0, 0, 0, 16'd0);
    go(16'd1, 16'd2, 2'b00);
    wait_until(e0 + 6);
    rst = 1'b1;
    wait_until(e0 + 7);
    rst = 1'b0;
    wait_until(e0 + 8);
    e0 = cyc + 1;
    exp_s1(e0, 16);
    go(16'd1, 16'd2, 2'b00);
    wait_until(e0 + 16);

    // pulse, single edge, stop coinciding with completion
    e0 = cyc + 1;
    push(e0,     2'b00, 0, 0, 0, 16'd0);
    push(e0 + 1, 2'b00, 1, 0, 0, 16'd0);
    push(e0 + 2, 2'b10, 1, 0, 0, 16'd1);
    push(e0 + 3, 2'b00, 0, 1, 0, 16'd1);
    push(e0 + 4, 2'b00, 0, 0, 0, 16'd1);
    go(16'd0, 16'd1, 2'b10);
    wait_until(e0 + 2);
    stop = 1'b1;
    wait_until(e0 + 3);
    stop = 1'b0;
    wait_until(e0 + 4);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
